// File: rtl/experiment_sequencer.sv
// rtl/experiment_sequencer.sv - run-control sequencer: GPIO register decode, DMA steering, experiment phase FSM
module experiment_sequencer #(
    parameter logic [15:0] RUN_ADDR    = 16'h0040,
    parameter logic [15:0] HALT_ADDR   = 16'h0041,
    parameter logic [15:0] SEL_ADDR    = 16'h0042,
    parameter logic [15:0] ROUNDS_ADDR = 16'h0043,
    parameter int          CLR_CYCLES  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  gpio_in,
    input  logic [127:0] s2_axis_tdata,
    input  logic         s2_axis_tvalid,
    output logic         s2_axis_tready,
    output logic [127:0] instr_wr_data,
    output logic         instr_wr_valid,
    input  logic         instr_wr_ready,
    output logic [127:0] b_wr_data,
    output logic         b_wr_valid,
    input  logic         b_wr_ready,
    output logic         dp_clear,
    output logic         dp_start,
    input  logic         dp_ready,
    output logic         dp_run,
    input  logic         dp_round_done,
    output logic [15:0]  prog_len,
    output logic [2:0]   ex_state,
    output logic [31:0]  status_word
);

    localparam int CW = (CLR_CYCLES < 2) ? 1 : $clog2(CLR_CYCLES);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_ARM      = 3'd2,
        S_RUN      = 3'd3,
        S_WAIT_RST = 3'd4
    } state_t;

    state_t state, state_next;

    logic [24:0]   gpio_s1, gpio_s2;
    logic          w_prev;
    logic          commit;
    logic [15:0]   gpio_addr;
    logic [7:0]    gpio_data;
    logic          unused_gpio;

    logic          run_bit, halt_bit, sel;
    logic [15:0]   round_limit;
    logic [15:0]   rounds_done;
    logic [15:0]   round_inc;
    logic          limit_hit;
    logic [CW-1:0] clr_cnt;
    logic          arm_first;
    logic          idle;
    logic          instr_accept;

    assign unused_gpio = ^gpio_in[31:25];

    // Two-flop synchronizer on the whole bus; a write commits on the rising edge of synced w_clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_s1 <= '0;
            gpio_s2 <= '0;
            w_prev  <= 1'b0;
        end else begin
            gpio_s1 <= gpio_in[24:0];
            gpio_s2 <= gpio_s1;
            w_prev  <= gpio_s2[24];
        end
    end

    assign commit    = gpio_s2[24] & ~w_prev;
    assign gpio_addr = gpio_s2[15:0];
    assign gpio_data = gpio_s2[23:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            run_bit     <= 1'b0;
            halt_bit    <= 1'b0;
            sel         <= 1'b0;
            round_limit <= '0;
        end else if (commit) begin
            case (gpio_addr)
                RUN_ADDR:    run_bit     <= gpio_data[0];
                HALT_ADDR:   halt_bit    <= gpio_data[0];
                SEL_ADDR:    sel         <= gpio_data[0];
                ROUNDS_ADDR: round_limit <= {round_limit[7:0], gpio_data};
                default: ;
            endcase
        end
    end

    // DMA steering is only live in IDLE so beats arriving mid-experiment stall rather than drop.
    assign idle           = (state == S_IDLE);
    assign instr_wr_data  = s2_axis_tdata;
    assign b_wr_data      = s2_axis_tdata;
    assign instr_wr_valid = idle & s2_axis_tvalid & ~sel;
    assign b_wr_valid     = idle & s2_axis_tvalid & sel;
    assign s2_axis_tready = idle & (sel ? b_wr_ready : instr_wr_ready);
    assign instr_accept   = instr_wr_valid & instr_wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            prog_len <= '0;
        end else if (commit && gpio_addr == SEL_ADDR && !gpio_data[0]) begin
            prog_len <= '0;
        end else if (instr_accept && prog_len != 16'hFFFF) begin
            prog_len <= prog_len + 16'd1;
        end
    end

    assign round_inc = (rounds_done == 16'hFFFF) ? 16'hFFFF : rounds_done + 16'd1;
    assign limit_hit = dp_round_done && (round_limit != 16'd0) && (round_inc == round_limit);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (run_bit && !halt_bit) state_next = S_CLEAR;
            end
            S_CLEAR: begin
                if (halt_bit)                 state_next = S_WAIT_RST;
                else if (clr_cnt == CLR_LAST) state_next = S_ARM;
            end
            S_ARM: begin
                if (halt_bit)      state_next = S_WAIT_RST;
                else if (dp_ready) state_next = S_RUN;
            end
            S_RUN: begin
                if (halt_bit || limit_hit) state_next = S_WAIT_RST;
            end
            S_WAIT_RST: begin
                if (!run_bit && !halt_bit) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            clr_cnt   <= '0;
            arm_first <= 1'b0;
        end else begin
            state     <= state_next;
            clr_cnt   <= (state == S_CLEAR) ? clr_cnt + 1'b1 : '0;
            arm_first <= (state != S_ARM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rounds_done <= '0;
        end else if (state == S_IDLE && state_next == S_CLEAR) begin
            rounds_done <= '0;
        end else if (state == S_RUN && dp_round_done) begin
            rounds_done <= round_inc;
        end
    end

    assign dp_clear    = (state == S_CLEAR);
    assign dp_start    = (state == S_ARM) && arm_first;
    assign dp_run      = (state == S_RUN);
    assign ex_state    = state;
    assign status_word = {rounds_done, 13'b0, state};

endmodule

// File: tb/tb_experiment_sequencer.sv
// tb/tb_experiment_sequencer.sv - directed/randomized self-checking bench for experiment_sequencer
module tb_experiment_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  gpio_in;
    logic [127:0] s2_axis_tdata;
    logic         s2_axis_tvalid;
    logic         s2_axis_tready;
    logic [127:0] instr_wr_data;
    logic         instr_wr_valid;
    logic         instr_wr_ready;
    logic [127:0] b_wr_data;
    logic         b_wr_valid;
    logic         b_wr_ready;
    logic         dp_clear;
    logic         dp_start;
    logic         dp_ready;
    logic         dp_run;
    logic         dp_round_done;
    logic [15:0]  prog_len;
    logic [2:0]   ex_state;
    logic [31:0]  status_word;

    int checks = 0;
    int errors = 0;

    localparam int CLR = 4;

    experiment_sequencer dut (
        .clk(clk), .rst(rst), .gpio_in(gpio_in),
        .s2_axis_tdata(s2_axis_tdata), .s2_axis_tvalid(s2_axis_tvalid), .s2_axis_tready(s2_axis_tready),
        .instr_wr_data(instr_wr_data), .instr_wr_valid(instr_wr_valid), .instr_wr_ready(instr_wr_ready),
        .b_wr_data(b_wr_data), .b_wr_valid(b_wr_valid), .b_wr_ready(b_wr_ready),
        .dp_clear(dp_clear), .dp_start(dp_start), .dp_ready(dp_ready), .dp_run(dp_run),
        .dp_round_done(dp_round_done), .prog_len(prog_len), .ex_state(ex_state), .status_word(status_word)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic gpio_write(input logic [15:0] addr, input logic [7:0] data);
        gpio_in = {8'h00, data, addr};
        tick();
        gpio_in[24] = 1'b1;
        tick();
        tick();
        gpio_in[24] = 1'b0;
        tick();
    endtask

    function automatic logic [127:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called right after the RUN=1 commit edge; walks CLEAR and lands on the first ARM cycle.
    task automatic expect_clear_arm(input string tag);
        settle();
        check({tag, "_pre_idle"}, ex_state, 3'd0);
        tick();
        for (int i = 0; i < CLR; i++) begin
            settle();
            check({tag, "_clear_state"}, ex_state, 3'd1);
            check({tag, "_clear_out"}, {dp_clear, dp_start, dp_run}, 3'b100);
            tick();
        end
        settle();
        check({tag, "_arm_state"}, ex_state, 3'd2);
        check({tag, "_arm_start"}, {dp_clear, dp_start, dp_run}, 3'b010);
        check({tag, "_rounds_cleared"}, status_word[31:16], 16'd0);
    endtask

    initial begin
        int acc;
        int exp_len;
        int n_rounds;
        int exp_rounds;
        int cyc;

        rst = 1'b1;
        gpio_in = '0;
        s2_axis_tdata = '0;
        s2_axis_tvalid = 1'b0;
        instr_wr_ready = 1'b0;
        b_wr_ready = 1'b0;
        dp_ready = 1'b0;
        dp_round_done = 1'b0;
        exp_len = 0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("reset_state", ex_state, 3'd0);
        check("reset_status", status_word, 32'h0);
        check("reset_prog_len", prog_len, 16'h0);
        check("reset_dp", {dp_clear, dp_start, dp_run}, 3'b000);
        check("reset_tready", s2_axis_tready, 1'b0);

        // Instruction stream
        gpio_write(16'h0042, 8'h00);
        s2_axis_tvalid = 1'b1;
        s2_axis_tdata = rand_beat();
        acc = 0;
        cyc = 0;
        while (acc < 12 && cyc < 300) begin
            instr_wr_ready = 1'($urandom_range(0, 1));
            b_wr_ready = 1'($urandom_range(0, 1));
            settle();
            check("instr_valid", instr_wr_valid, 1'b1);
            check("instr_b_valid_low", b_wr_valid, 1'b0);
            check("instr_tready", s2_axis_tready, instr_wr_ready);
            check("instr_data", instr_wr_data, s2_axis_tdata);
            tick();
            if (instr_wr_ready) begin
                acc++;
                exp_len++;
                s2_axis_tdata = rand_beat();
            end
            cyc++;
        end
        check("instr_stream_done", acc, 12);
        s2_axis_tvalid = 1'b0;
        instr_wr_ready = 1'b0;
        b_wr_ready = 1'b0;
        settle();
        check("prog_len_12", prog_len, 16'(exp_len));

        // B stream
        gpio_write(16'h0042, 8'h01);
        s2_axis_tvalid = 1'b1;
        s2_axis_tdata = rand_beat();
        acc = 0;
        cyc = 0;
        while (acc < 9 && cyc < 300) begin
            instr_wr_ready = 1'($urandom_range(0, 1));
            b_wr_ready = 1'($urandom_range(0, 1));
            settle();
            check("b_valid", b_wr_valid, 1'b1);
            check("b_instr_valid_low", instr_wr_valid, 1'b0);
            check("b_tready", s2_axis_tready, b_wr_ready);
            check("b_data", b_wr_data, s2_axis_tdata);
            tick();
            if (b_wr_ready) begin
                acc++;
                s2_axis_tdata = rand_beat();
            end
            cyc++;
        end
        check("b_stream_done", acc, 9);
        s2_axis_tvalid = 1'b0;
        instr_wr_ready = 1'b0;
        b_wr_ready = 1'b0;
        settle();
        check("prog_len_held", prog_len, 16'(exp_len));

        // Limited run with DMA held off during the experiment
        n_rounds = $urandom_range(2, 7);
        gpio_write(16'h0043, 8'h00);
        gpio_write(16'h0043, 8'(n_rounds));
        dp_ready = 1'b1;
        gpio_write(16'h0040, 8'h01);
        expect_clear_arm("lim");
        tick();
        settle();
        check("lim_run_state", ex_state, 3'd3);
        check("lim_run_out", {dp_clear, dp_start, dp_run}, 3'b001);
        s2_axis_tvalid = 1'b1;
        s2_axis_tdata = rand_beat();
        b_wr_ready = 1'b1;
        instr_wr_ready = 1'b1;
        exp_rounds = 0;
        for (int p = 0; p < n_rounds; p++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                settle();
                check("lim_gap_state", ex_state, 3'd3);
                check("lim_gap_tready", s2_axis_tready, 1'b0);
                tick();
            end
            dp_round_done = 1'b1;
            settle();
            check("lim_pulse_state", ex_state, 3'd3);
            check("lim_pulse_tready", {s2_axis_tready, b_wr_valid, instr_wr_valid}, 3'b000);
            tick();
            dp_round_done = 1'b0;
            exp_rounds++;
        end
        settle();
        check("lim_done_status", status_word, {16'(exp_rounds), 13'b0, 3'd4});
        check("lim_wait_dp", {dp_clear, dp_start, dp_run}, 3'b000);
        check("lim_wait_tready", s2_axis_tready, 1'b0);
        gpio_write(16'h0040, 8'h00);
        settle();
        check("lim_still_wait", ex_state, 3'd4);
        check("lim_wait_tready2", s2_axis_tready, 1'b0);
        tick();
        settle();
        check("lim_idle", ex_state, 3'd0);
        check("held_beat_accept", {s2_axis_tready, b_wr_valid}, 2'b11);
        check("lim_rounds_kept", status_word[31:16], 16'(exp_rounds));
        tick();
        s2_axis_tvalid = 1'b0;
        b_wr_ready = 1'b0;
        instr_wr_ready = 1'b0;

        // Unlimited run, then halt
        gpio_write(16'h0043, 8'h00);
        gpio_write(16'h0043, 8'h00);
        gpio_write(16'h0040, 8'h01);
        expect_clear_arm("unl");
        tick();
        exp_rounds = 0;
        for (int c = 0; c < 100; c++) begin
            dp_round_done = 1'($urandom_range(0, 1));
            settle();
            check("unl_run_state", ex_state, 3'd3);
            tick();
            if (dp_round_done) exp_rounds++;
        end
        dp_round_done = 1'b0;
        settle();
        check("unl_rounds", status_word[31:16], 16'(exp_rounds));
        gpio_write(16'h0041, 8'h01);
        settle();
        check("halt_pre", ex_state, 3'd3);
        tick();
        settle();
        check("halt_wait", ex_state, 3'd4);
        check("halt_dp_low", {dp_clear, dp_start, dp_run}, 3'b000);
        gpio_write(16'h0041, 8'h00);
        tick();
        settle();
        check("halt_run_still_set", ex_state, 3'd4);
        gpio_write(16'h0040, 8'h00);
        tick();
        settle();
        check("halt_idle", ex_state, 3'd0);

        // ARM stall with dp_ready low
        dp_ready = 1'b0;
        gpio_write(16'h0040, 8'h01);
        expect_clear_arm("stall");
        tick();
        for (int c = 0; c < 20; c++) begin
            settle();
            check("stall_state", ex_state, 3'd2);
            check("stall_no_start", dp_start, 1'b0);
            tick();
        end
        dp_ready = 1'b1;
        tick();
        settle();
        check("stall_run", ex_state, 3'd3);

        // Reset mid-run after three rounds
        for (int p = 0; p < 3; p++) begin
            dp_round_done = 1'b1;
            tick();
            dp_round_done = 1'b0;
            tick();
        end
        settle();
        check("pre_rst_rounds", status_word, {16'd3, 13'b0, 3'd3});
        check("pre_rst_prog_len", prog_len, 16'(exp_len));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rst_state", ex_state, 3'd0);
        check("rst_status", status_word, 32'h0);
        check("rst_prog_len", prog_len, 16'h0);
        check("rst_dp", {dp_clear, dp_start, dp_run}, 3'b000);
        check("rst_tready", {s2_axis_tready, instr_wr_valid, b_wr_valid}, 3'b000);
        tick();
        settle();
        check("rst_stays_idle", ex_state, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/experiment_sequencer.md
# experiment_sequencer

Run-control sequencer for the Ising experiment datapath, instantiated inside the experiment top level between the PS GPIO register bus, the CPU DMA stream and the MAC/NL/DAC pipeline. It decodes the GPIO run/halt/select/round-limit registers and steers DMA beats to the instruction memory or the B buffer while idle. It sequences each experiment through clear, arm, run and wait-for-reset phases, counts completed rounds, and reports state on a status word.

## Interface
- RUN_ADDR, 16'h0040, GPIO address of run level bit (data[0])
- HALT_ADDR, 16'h0041, GPIO address of halt level bit (data[0])
- SEL_ADDR, 16'h0042, GPIO address of DMA target select (data[0]: 0 = instr, 1 = B)
- ROUNDS_ADDR, 16'h0043, GPIO address of round limit, byte-serial MSB first
- CLR_CYCLES, 4, cycles dp_clear is held in CLEAR (≥1)
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- gpio_in  in  32  [15:0] addr, [23:16] data, [24] w_clk strobe, [31:25] ignored
- s2_axis_tdata  in  128  DMA beat data
- s2_axis_tvalid  in  1  DMA beat valid
- s2_axis_tready  out  1  DMA beat accept
- instr_wr_data / b_wr_data  out  128 each  steered beat data (both = s2_axis_tdata)
- instr_wr_valid / b_wr_valid  out  1 each  steered valid
- instr_wr_ready / b_wr_ready  in  1 each  downstream ready
- dp_clear  out  1  clear datapath accumulators/pointers
- dp_start  out  1  one-cycle start pulse
- dp_ready  in  1  datapath acknowledges start
- dp_run  out  1  datapath enable
- dp_round_done  in  1  one-cycle pulse per completed round
- prog_len  out  16  instruction beats accepted since last SEL=0 write
- ex_state  out  3  FSM state
- status_word  out  32  {rounds_done[15:0], 13'b0, ex_state}

## Operation
- GPIO write capture: gpio_in[24:0] passes a 2-flop synchronizer; a write commits when synced w_clk is 1 and its previous sample was 0, using the synced addr/data. Unmatched addresses are ignored.
- Register effects:
  - RUN → run_bit = data[0].
  - HALT → halt_bit = data[0].
  - SEL → sel = data[0]; prog_len cleared when data[0] = 0.
  - ROUNDS → round_limit <= {round_limit[7:0], data}.
- States and encodings: IDLE=0, CLEAR=1, ARM=2, RUN=3, WAIT_RST=4.
- IDLE → CLEAR when run_bit && !halt_bit.
- CLEAR: dp_clear = 1 for exactly CLR_CYCLES cycles, then → ARM. rounds_done cleared on entry.
- ARM: dp_start = 1 on the first ARM cycle only. Stays in ARM until dp_ready = 1, then → RUN.
- RUN: dp_run = 1.
  - Each dp_round_done increments rounds_done, saturating at 16'hFFFF.
  - If round_limit ≠ 0 and a pulse makes rounds_done == round_limit → WAIT_RST next cycle.
  - round_limit = 0 means run until halt.
- halt_bit = 1 in CLEAR, ARM or RUN → WAIT_RST next cycle; this takes priority over every other transition. halt_bit in IDLE: no effect.
- WAIT_RST: all dp_* outputs low. → IDLE when run_bit = 0 and halt_bit = 0.
- DMA steering, IDLE only:
  - s2_axis_tready = sel ? b_wr_ready : instr_wr_ready.
  - instr_wr_valid = s2_axis_tvalid && !sel.
  - b_wr_valid = s2_axis_tvalid && sel.
  - prog_len increments on each accepted instruction beat, saturating at 16'hFFFF.
- Outside IDLE: s2_axis_tready, instr_wr_valid and b_wr_valid are 0. Beats are held, not dropped.

## Timing
- Reset values: state IDLE, all outputs 0, run_bit/halt_bit/sel 0, round_limit 0, rounds_done 0, prog_len 0.
- Reset mid-run: dp_run drops the cycle after rst is sampled; pending DMA beats are not accepted.
- GPIO latency: w_clk first sampled high at edge k → register updated at edge k+2. w_clk must stay high ≥2 cycles, and addr/data must be stable from 1 cycle before w_clk through w_clk low.
- run_bit set at edge n:
  - ex_state = CLEAR after edge n+1.
  - dp_clear high for cycles n+1 .. n+CLR_CYCLES.
  - ARM entered after edge n+CLR_CYCLES+1, with dp_start high that cycle.
- dp_ready sampled high in ARM → RUN after the next edge. If dp_ready is already high on ARM entry, ARM lasts exactly 1 cycle.
- dp_round_done coincident with a halt commit: the count still increments; the state goes to WAIT_RST.
- Steering is combinational (zero latency). The accept condition is the handshake in the same cycle.
- Writing sel while a beat is stalled: the new sel takes effect for that beat from the commit cycle.

## Test plan
- Reset, then write SEL=0 and stream 12 beats with instr_wr_ready toggling 1/0 → exactly 12 accepted, prog_len=12, b_wr_valid never high. Then SEL=1 and 9 beats → b_wr_valid only, prog_len stays 12.
- Write ROUNDS 8'h00 then 8'h05, RUN=1, hold dp_ready=1, pulse dp_round_done 5 times → states 1 (4 cycles) → 2 (1 cycle, dp_start) → 3. After the 5th pulse: state 4, status_word = 32'h0005_0004.
- ROUNDS=0, RUN=1, wait 100 cycles in RUN → ex_state=3. HALT=1 → ex_state=4 two cycles after w_clk. Then HALT=0 and RUN=0 → ex_state=0.
- Hold dp_ready=0 for 20 cycles in ARM → dp_start is a single pulse, state stays 2; raise dp_ready → state 3 next cycle.
- DMA valid held during RUN → s2_axis_tready=0 throughout; the beat is accepted in the first IDLE cycle after WAIT_RST exits.
- Assert rst for 1 cycle while in RUN with rounds_done=3 → all outputs 0, ex_state=0, round_limit=0, prog_len=0 next cycle.
